// File: rtl/sram_emulator.sv
// Synthesizable async-SRAM pin responder backed by inferred BRAM, with transaction counters.
// Optional protocol-timing error flags are built when SRAM_TIMING_CHECK_EN is defined.
module sram_emulator #(
    parameter int ADDR_WIDTH          = 17,
    parameter int READ_LATENCY_CYCLES = 3,
    parameter int MIN_WE_CYCLES       = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] sram_a,
    inout  wire  [15:0]           sram_dq,
    input  logic                  sram_oe_n,
    input  logic                  sram_we_n,
    input  logic                  sram_ub_n,
    input  logic                  sram_lb_n,
    output logic [15:0]           wr_count,
    output logic [15:0]           rd_count,
    output logic [1:0]            err_timing
);
    localparam int         DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [3:0] LAT   = 4'(READ_LATENCY_CYCLES);

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_e;

    logic [ADDR_WIDTH-1:0] a_q;
    logic [15:0]           dq_in_q;
    logic                  oe_q, we_q, ub_q, lb_q;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [15:0]           wdata_q, wdata_d;
    logic [1:0]            wbe_q, wbe_d;
    logic [3:0]            lat_q, lat_d;
    logic                  drove_q, drove_d;
    logic [15:0]           wr_cnt_q, wr_cnt_d;
    logic [15:0]           rd_cnt_q, rd_cnt_d;
    logic                  mem_we;

    logic [15:0]           mem [DEPTH];
    logic [15:0]           rd_data_q;

    logic                  lane_act;
    logic [1:0]            lane_en;
    logic                  drive;
    logic [1:0]            dq_en;

    assign lane_en  = {~ub_q, ~lb_q};
    assign lane_act = |lane_en;
    // Drive only from flopped state so an async reset releases the bus with no clock edge.
    assign drive    = (state_q == READ) && (lat_q == LAT) && (a_q == addr_q);
    assign dq_en    = drive ? lane_en : 2'b00;

    assign sram_dq[15:8] = dq_en[1] ? rd_data_q[15:8] : 8'hzz;
    assign sram_dq[7:0]  = dq_en[0] ? rd_data_q[7:0]  : 8'hzz;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q     <= '0;
            dq_in_q <= '0;
            oe_q    <= 1'b1;
            we_q    <= 1'b1;
            ub_q    <= 1'b1;
            lb_q    <= 1'b1;
        end else begin
            a_q     <= sram_a;
            dq_in_q <= sram_dq;
            oe_q    <= sram_oe_n;
            we_q    <= sram_we_n;
            ub_q    <= sram_ub_n;
            lb_q    <= sram_lb_n;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wbe_d    = wbe_q;
        lat_d    = lat_q;
        drove_d  = drove_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        mem_we   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!we_q && lane_act) begin
                    state_d = WRITE;
                    addr_d  = a_q;
                    wdata_d = dq_in_q;
                    wbe_d   = lane_en;
                end else if (!oe_q && lane_act) begin
                    state_d = READ;
                    addr_d  = a_q;
                    lat_d   = '0;
                    drove_d = 1'b0;
                end
            end
            WRITE: begin
                // Terminating cycle commits what was latched before it, not the current pins.
                if (we_q || !lane_act) begin
                    mem_we   = 1'b1;
                    wr_cnt_d = wr_cnt_q + 16'd1;
                    state_d  = IDLE;
                end else begin
                    addr_d  = a_q;
                    wdata_d = dq_in_q;
                    wbe_d   = lane_en;
                end
            end
            READ: begin
                if (!lane_act || (oe_q && we_q)) begin
                    if (drove_q || (|dq_en)) rd_cnt_d = rd_cnt_q + 16'd1;
                    state_d = IDLE;
                end else if (!we_q) begin
                    state_d = WRITE;
                    addr_d  = a_q;
                    wdata_d = dq_in_q;
                    wbe_d   = lane_en;
                end else if (a_q != addr_q) begin
                    addr_d = a_q;
                    lat_d  = '0;
                end else begin
                    if (lat_q != LAT) lat_d = lat_q + 4'd1;
                    if (|dq_en) drove_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            wbe_q    <= '0;
            lat_q    <= '0;
            drove_q  <= 1'b0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wbe_q    <= wbe_d;
            lat_q    <= lat_d;
            drove_q  <= drove_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
        end
    end

    // Memory is deliberately not reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            if (wbe_q[1]) mem[addr_q][15:8] <= wdata_q[15:8];
            if (wbe_q[0]) mem[addr_q][7:0]  <= wdata_q[7:0];
        end
        rd_data_q <= mem[addr_q];
    end

    assign wr_count = wr_cnt_q;
    assign rd_count = rd_cnt_q;

`ifdef SRAM_TIMING_CHECK_EN
    localparam logic [4:0] MIN_WE = 5'(MIN_WE_CYCLES);

    logic [3:0] we_cnt_q, we_cnt_d;
    logic [1:0] err_q, err_d;
    logic       wr_start, wr_end;

    assign wr_start = (state_d == WRITE) && (state_q != WRITE);
    assign wr_end   = (state_q == WRITE) && (state_d != WRITE);

    always_comb begin
        we_cnt_d = we_cnt_q;
        err_d    = err_q;
        if (wr_start) we_cnt_d = 4'd1;
        else if ((state_q == WRITE) && !wr_end && (we_cnt_q != 4'hF)) we_cnt_d = we_cnt_q + 4'd1;
        if (wr_end && ({1'b0, we_cnt_q} < MIN_WE)) err_d[0] = 1'b1;
        if (!we_q && (|dq_en)) err_d[1] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we_cnt_q <= '0;
            err_q    <= '0;
        end else begin
            we_cnt_q <= we_cnt_d;
            err_q    <= err_d;
        end
    end

    assign err_timing = err_q;
`else
    assign err_timing = 2'b00;
`endif
endmodule
